// File: rtl/lc3_mem_if.sv
// ============================================================================
// Module   : lc3_mem_if
// Purpose  : LC-3 MAR/MDR holder and request/acknowledge memory handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_mem_if #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   inout  wire  [15:0] main_bus,
   input  logic        LDMAR,
   input  logic        LDMDR,
   input  logic        GateMDR,
   input  logic        MIO_EN,
   input  logic        R_W,
   output logic        R,
   output logic        mem_err,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   input  logic [15:0] mem_rdata,
   input  logic        mem_ack
);

   localparam logic [1:0] c_IDLE     = 2'd0;
   localparam logic [1:0] c_REQ      = 2'd1;
   localparam logic [1:0] c_COMPLETE = 2'd2;
   localparam logic [1:0] c_RELEASE  = 2'd3;

   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  r_state;
   logic [15:0] r_mar;
   logic [15:0] r_mdr;
   logic [15:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= c_IDLE;
         r_mar    <= 16'h0000;
         r_mdr    <= 16'h0000;
         r_cnt    <= 16'h0000;
         mem_addr <= 16'h0000;
         mem_we   <= 1'b0;
         mem_err  <= 1'b0;
      end else begin
         if (LDMAR)
            r_mar <= main_bus;
         // Bus loads of MDR never compete with returning memory data.
         if (LDMDR && !MIO_EN && (r_state != c_REQ))
            r_mdr <= main_bus;

         case (r_state)
            c_IDLE: begin
               if (MIO_EN) begin
                  mem_addr <= r_mar;
                  mem_we   <= R_W;
                  r_cnt    <= 16'h0000;
                  mem_err  <= 1'b0;
                  r_state  <= c_REQ;
               end
            end
            c_REQ: begin
               if (mem_ack) begin
                  if (!mem_we)
                     r_mdr <= mem_rdata;
                  r_state <= c_COMPLETE;
               end else if (r_cnt == c_TMO_LAST) begin
                  mem_err <= 1'b1;
                  r_state <= c_COMPLETE;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            c_COMPLETE: begin
               r_state <= MIO_EN ? c_RELEASE : c_IDLE;
            end
            c_RELEASE: begin
               // A held enable must fall before another access may start.
               if (!MIO_EN)
                  r_state <= c_IDLE;
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign mem_req   = (r_state == c_REQ);
   assign R         = (r_state == c_COMPLETE);
   assign mem_wdata = r_mdr;
   assign main_bus  = GateMDR ? r_mdr : 16'hzzzz;

endmodule

`default_nettype wire

// File: tb/tb_lc3_mem_if.sv
// ============================================================================
// Module   : tb_lc3_mem_if
// Purpose  : Vector-table bench for lc3_mem_if plus reset corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lc3_mem_if;

   logic        clk = 1'b0;
   logic        rst;
   logic        LDMAR, LDMDR, GateMDR, MIO_EN, R_W, mem_ack;
   logic [15:0] mem_rdata;
   logic        R, mem_err, mem_req, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic        drv;
   logic [15:0] bus_val;
   wire  [15:0] main_bus;

   int n_vec = 0;
   int n_bad = 0;

   assign main_bus = drv ? bus_val : 16'hzzzz;

   always #5 clk = ~clk;

   lc3_mem_if #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .main_bus(main_bus),
      .LDMAR(LDMAR), .LDMDR(LDMDR), .GateMDR(GateMDR),
      .MIO_EN(MIO_EN), .R_W(R_W), .R(R), .mem_err(mem_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
   );

   typedef struct {
      logic [5:0]  ctl;    // {ldmar, ldmdr, gate, mio, rw, drv}
      logic [15:0] bus;
      logic        ack;
      logic [15:0] rdata;
      logic [3:0]  flags;  // {req, r, err, we}
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] obus;   // checked only when gate is set
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [5:0] ctl, input logic [15:0] bus,
                               input logic ack, input logic [15:0] rdata,
                               input logic [3:0] flags, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] obus);
      vec_t v;
      v.ctl = ctl; v.bus = bus; v.ack = ack; v.rdata = rdata;
      v.flags = flags; v.addr = addr; v.wdata = wdata; v.obus = obus;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; LDMAR = 0; LDMDR = 0; GateMDR = 0; MIO_EN = 0; R_W = 0;
      mem_ack = 0; mem_rdata = 16'h0; drv = 0; bus_val = 16'h0;

      // ctl bits: ldmar ldmdr gate mio rw drv ; flags: req r err we
      // fetch read, ack on third REQ cycle
      vecs.push_back(mk(6'b100001, 16'h0200, 0, 16'h0000, 4'b0000, 16'h0000, 16'h0000, 16'h0));
      vecs.push_back(mk(6'b000100, 16'h0000, 0, 16'h0000, 4'b1000, 16'h0200, 16'h0000, 16'h0));
      vecs.push_back(mk(6'b000100, 16'h0000, 0, 16'h0000, 4'b1000, 16'h0200, 16'h0000, 16'h0));
      vecs.push_back(mk(6'b000100, 16'h0000, 0, 16'h0000, 4'b1000, 16'h0200, 16'h0000, 16'h0));
      vecs.push_back(mk(6'b001100, 16'h0000, 1, 16'h1234, 4'b0100, 16'h0200, 16'h1234, 16'h1234));
      vecs.push_back(mk(6'b001000, 16'h0000, 0, 16'h0000, 4'b0000, 16'h0200, 16'h1234, 16'h1234));
      // write with immediate ack
      vecs.push_back(mk(6'b100001, 16'h3000, 0, 16'h0000, 4'b0000, 16'h0200, 16'h1234, 16'h0));
      vecs.push_back(mk(6'b010001, 16'hBEEF, 0, 16'h0000, 4'b0000, 16'h0200, 16'hBEEF, 16'h0));
      vecs.push_back(mk(6'b000110, 16'h0000, 0, 16'h0000, 4'b1001, 16'h3000, 16'hBEEF, 16'h0));
      vecs.push_back(mk(6'b001110, 16'h0000, 1, 16'h0000, 4'b0101, 16'h3000, 16'hBEEF, 16'hBEEF));
      // enable held high for five cycles after R
      for (int i = 0; i < 5; i++)
         vecs.push_back(mk(6'b001100, 16'h0000, 0, 16'h0000, 4'b0001, 16'h3000, 16'hBEEF, 16'hBEEF));
      vecs.push_back(mk(6'b000000, 16'h0000, 0, 16'h0000, 4'b0001, 16'h3000, 16'hBEEF, 16'h0));
      // timeout after four REQ cycles
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(6'b000100, 16'h0000, 0, 16'h0000, 4'b1000, 16'h3000, 16'hBEEF, 16'h0));
      vecs.push_back(mk(6'b001100, 16'h0000, 0, 16'h0000, 4'b0110, 16'h3000, 16'hBEEF, 16'hBEEF));
      vecs.push_back(mk(6'b000000, 16'h0000, 0, 16'h0000, 4'b0010, 16'h3000, 16'hBEEF, 16'h0));
      // next access clears the error; MAR/MDR loads during REQ
      vecs.push_back(mk(6'b000100, 16'h0000, 0, 16'h0000, 4'b1000, 16'h3000, 16'hBEEF, 16'h0));
      vecs.push_back(mk(6'b100101, 16'hFFFF, 0, 16'h0000, 4'b1000, 16'h3000, 16'hBEEF, 16'h0));
      vecs.push_back(mk(6'b010001, 16'h0000, 0, 16'h0000, 4'b1000, 16'h3000, 16'hBEEF, 16'h0));
      vecs.push_back(mk(6'b001000, 16'h0000, 1, 16'h5A5A, 4'b0100, 16'h3000, 16'h5A5A, 16'h5A5A));
      vecs.push_back(mk(6'b001000, 16'h0000, 0, 16'h0000, 4'b0000, 16'h3000, 16'h5A5A, 16'h5A5A));
      // new MAR appears only at the next access; back-to-back restart
      vecs.push_back(mk(6'b000100, 16'h0000, 0, 16'h0000, 4'b1000, 16'hFFFF, 16'h5A5A, 16'h0));
      vecs.push_back(mk(6'b000100, 16'h0000, 1, 16'h0F0F, 4'b0100, 16'hFFFF, 16'h0F0F, 16'h0));
      vecs.push_back(mk(6'b000000, 16'h0000, 1, 16'h1111, 4'b0000, 16'hFFFF, 16'h0F0F, 16'h0));
      vecs.push_back(mk(6'b001100, 16'h0000, 0, 16'h0000, 4'b1000, 16'hFFFF, 16'h0F0F, 16'h0F0F));
      vecs.push_back(mk(6'b000000, 16'h0000, 1, 16'h2222, 4'b0100, 16'hFFFF, 16'h2222, 16'h0));
      // MDR bus load from COMPLETE with enable low
      vecs.push_back(mk(6'b010001, 16'h7777, 0, 16'h0000, 4'b0000, 16'hFFFF, 16'h7777, 16'h0));
      vecs.push_back(mk(6'b001000, 16'h0000, 0, 16'h0000, 4'b0000, 16'hFFFF, 16'h7777, 16'h7777));

      repeat (2) step();
      chk("reset_outputs", {48'h0, R, mem_err, mem_req, mem_we, mem_addr, mem_wdata}, 64'h0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         {LDMAR, LDMDR, GateMDR, MIO_EN, R_W, drv} = vecs[i].ctl;
         bus_val   = vecs[i].bus;
         mem_ack   = vecs[i].ack;
         mem_rdata = vecs[i].rdata;
         step();
         chk($sformatf("vec%0d", i),
             {12'h0, mem_req, R, mem_err, mem_we, mem_addr, mem_wdata,
              (GateMDR ? main_bus : 16'h0)},
             {12'h0, vecs[i].flags, vecs[i].addr, vecs[i].wdata,
              (vecs[i].ctl[3] ? vecs[i].obus : 16'h0)});
      end
      {LDMAR, LDMDR, GateMDR, MIO_EN, R_W, drv} = 6'b0;
      mem_ack = 0;

      // sticky error cleared by reset
      MIO_EN = 1;
      repeat (5) step();
      chk("timeout_err", {62'h0, R, mem_err}, 64'h3);
      MIO_EN = 0;
      step();
      #2 rst = 1'b1;
      #1 chk("rst_clears_err", {63'h0, mem_err}, 64'h0);
      #1 rst = 1'b0;

      // reset asserted mid-REQ
      MIO_EN = 1;
      step();
      step();
      chk("in_req_before_rst", {63'h0, mem_req}, 64'h1);
      #2 rst = 1'b1;
      #1 chk("rst_mid_req", {44'h0, R, mem_err, mem_req, mem_we, mem_addr}, 64'h0);
      GateMDR = 1;
      #1 chk("rst_mdr_zero", {48'h0, main_bus}, 64'h0);
      GateMDR = 0;
      rst = 1'b0;
      step();
      chk("mar_zero_after_rst", {47'h0, mem_req, mem_addr}, {47'h0, 1'b1, 16'h0000});
      mem_ack = 1; mem_rdata = 16'hABCD;
      step();
      chk("final_read", {47'h0, R, mem_wdata}, {47'h0, 1'b1, 16'hABCD});
      mem_ack = 0; MIO_EN = 0;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/lc3_mem_if.md
# lc3_mem_if

Memory interface stage for the LC-3 datapath: holds the MAR and MDR and runs the handshake with external memory. It sits directly downstream of the program counter. During fetch, the PC value driven onto `main_bus` is loaded into MAR, and the fetched word returns through MDR. The block turns the control FSM's level-style `MIO_EN`/`R_W` strobes into a registered request/acknowledge transaction, and returns a one-cycle `R` (ready) pulse that the control FSM uses to advance.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles spent in REQ without `mem_ack` before the access is aborted. Legal range 1..65535.
- `clk` input 1: clock; all state changes on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `main_bus` inout 16: shared datapath bus; source for MAR/MDR loads; driven by MDR when `GateMDR`=1, else `16'hZZZZ`.
- `LDMAR` input 1: load MAR from `main_bus`.
- `LDMDR` input 1: load MDR from `main_bus`; honoured only when `MIO_EN`=0 and the state is not REQ.
- `GateMDR` input 1: drive MDR onto `main_bus`.
- `MIO_EN` input 1: memory access enable (level, from control FSM).
- `R_W` input 1: 1 = write, 0 = read; sampled when the access starts.
- `R` output 1: access complete; one-cycle pulse.
- `mem_err` output 1: last access timed out; sticky until the next access starts.
- `mem_req` output 1: request to memory.
- `mem_we` output 1: write enable accompanying `mem_req`.
- `mem_addr` output 16: address, latched at access start.
- `mem_wdata` output 16: write data, equals MDR.
- `mem_rdata` input 16: read data, valid when `mem_ack`=1.
- `mem_ack` input 1: memory completion, sampled only in REQ.

## Operation
- Registers: MAR, MDR, `mem_addr`, `mem_we`, `state`, and a 16-bit timeout counter.
- Reset values: MAR=0, MDR=0, `mem_addr`=0, `mem_we`=0, `mem_req`=0, `R`=0, `mem_err`=0, counter=0, state=IDLE.
- MAR loads on `LDMAR` in any state.
- `mem_addr` is a separate copy of MAR, taken at access start. A later MAR load does not disturb an in-flight request.
- States:
  - **IDLE**: if `MIO_EN`=1, capture `mem_addr`<=MAR and `mem_we`<=`R_W`, clear the counter and `mem_err`, and go to REQ. Otherwise stay.
  - **REQ**: `mem_req`=1.
    - If `mem_ack`=1: on a read, MDR<=`mem_rdata`; on a write, MDR is unchanged. Go to COMPLETE.
    - Else if counter = `TIMEOUT_CYCLES`-1: set `mem_err`=1, leave MDR unchanged, go to COMPLETE.
    - Else increment the counter.
  - **COMPLETE**: `R`=1. Go to IDLE if `MIO_EN`=0, else go to RELEASE.
  - **RELEASE**: `R`=0. Wait for `MIO_EN`=0, then go to IDLE. This prevents a held `MIO_EN` from re-triggering the same access.
- `MIO_EN` dropping while in REQ does not cancel the access. It completes normally, R still pulses, and the state returns to IDLE.
- `mem_ack` outside REQ is ignored.
- `LDMDR` while in REQ is ignored; memory data wins.
- `LDMDR` in COMPLETE or RELEASE with `MIO_EN`=0 loads from the bus.
- `GateMDR` is purely combinational and valid in every state.
- Reset asserted mid-access forces IDLE and the reset values immediately. `mem_req` drops asynchronously.

## Timing
- `mem_req`, `mem_we`, `mem_addr` and `R` are registered or decoded from state only. There are no combinational paths from `mem_ack` to the outputs.
- Minimum access:
  - `MIO_EN` sampled high at edge 0 → `mem_req`=1 after edge 0.
  - `mem_ack` sampled at edge 1 → MDR valid and `R`=1 after edge 1.
  - `R`=0 after edge 2.
- Read data is visible on `main_bus` via `GateMDR` in the same cycle `R`=1.
- `mem_req` stays high for exactly (number of cycles until ack sampled) cycles. It is never high in COMPLETE.
- Timeout: `mem_req` stays high for exactly `TIMEOUT_CYCLES` cycles, then `R` pulses with `mem_err`=1.
- Back-to-back accesses: `MIO_EN` low for one cycle after R, then high again → new REQ starts; no idle gap beyond that.

## Test plan
- Reset: assert `rst` mid-REQ → `mem_req`, `R`, `mem_err` go to 0 immediately; MAR=MDR=0; `main_bus` is Z with `GateMDR`=0.
- Fetch read: bus=`16'h0200` with `LDMAR`; `MIO_EN`=1, `R_W`=0; memory acks after 3 cycles with `16'h1234`.
  - Required: `mem_addr`=`16'h0200`; `mem_req` high 3 cycles; `R` pulses 1 cycle; MDR=`16'h1234`; `GateMDR` drives `16'h1234`.
- Write: MAR=`16'h3000`, MDR loaded `16'hBEEF` via `LDMDR`; `MIO_EN`=1, `R_W`=1; immediate ack.
  - Required: `mem_we`=1 and `mem_wdata`=`16'hBEEF` while `mem_req`; MDR still `16'hBEEF` after R.
- Held enable: `MIO_EN` held high 5 cycles after R.
  - Required: exactly one `mem_req` assertion; state stays in RELEASE until `MIO_EN` falls.
- Timeout with `TIMEOUT_CYCLES`=4 and no ack.
  - Required: `mem_req` high exactly 4 cycles; `R`=1 with `mem_err`=1; MDR unchanged.
  - Required: the next access clears `mem_err` at start.
- Interference: `LDMAR` with `16'hFFFF` and `LDMDR` with `16'h0000` during REQ; ack data `16'h5A5A`.
  - Required: `mem_addr` unchanged; MDR=`16'h5A5A`; MAR=`16'hFFFF`.
